mux_4bits: RTL and testbench
============================

MUX_4BITS -- requirements
Module: mux_4bits

Interface
REQ-001 Parameter: WIDTH, default 4, data width of every data input and output.
REQ-002 Parameter: RST_VAL, default all zeros (WIDTH bits), reset value of y_q.
REQ-003 Port: clk  input  1  sole clock; all registers update on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: a  input  WIDTH  data source 0.
REQ-006 Port: b  input  WIDTH  data source 1.
REQ-007 Port: c  input  WIDTH  data source 2.
REQ-008 Port: d  input  WIDTH  data source 3.
REQ-009 Port: sel  input  2  source select; 0=a, 1=b, 2=c, 3=d.
REQ-010 Port: en  input  1  capture enable for the registered path.
REQ-011 Port: y  output  WIDTH  combinational selected data.
REQ-012 Port: y_q  output  WIDTH  registered selected data.
REQ-013 Port: sel_oh  output  4  combinational one-hot decode of sel; bit i set when sel==i.
REQ-014 Port: chg  output  1  registered strobe; high one cycle after a capture that changed y_q.

Function
REQ-015 y SHALL equal a/b/c/d for sel 0/1/2/3, purely combinational, zero clock latency, independent of clk, rst and en.
REQ-016 y SHALL settle within the same simulation time step as any change on sel or the selected data input.
REQ-017 All four sel codes are legal; no default/X output for any 2-bit sel value; X on sel SHALL NOT be masked (y may go X).
REQ-018 sel_oh SHALL be exactly one-hot for every legal sel: 0->0001, 1->0010, 2->0100, 3->1000.
REQ-019 On a rising clk edge with en=1 and rst=0, y_q SHALL load the current value of y (1-cycle latency).
REQ-020 On a rising clk edge with en=0 and rst=0, y_q SHALL hold its value.
REQ-021 chg SHALL be set on a rising edge where en=1 and the loaded value differs from the previous y_q, and cleared on every other rising edge.
REQ-022 Selected-input change and sel change in the same cycle: y_q SHALL capture the value of y present at the edge; no ordering dependency.
REQ-023 No arithmetic; bit-exact pass-through, no width extension or truncation.

Reset
REQ-024 While rst=1, y_q SHALL be RST_VAL and chg SHALL be 0, asynchronously, without waiting for clk.
REQ-025 rst SHALL NOT affect y or sel_oh; both stay combinationally valid during reset.
REQ-026 Reset asserted mid-operation SHALL override en; the first enabled edge after rst deasserts loads y normally, with chg computed against RST_VAL.

Verification
REQ-027 Set a=0101, b=1001, c=0011, d=0001 with no clock running; step sel 0,1,2,3 waiting 2 time units each -> y=0101, 1001, 0011, 0001 and sel_oh=0001, 0010, 0100, 1000.
REQ-028 Same data, rst pulsed then released, en=1, sel=1, one rising edge -> y_q=1001, chg=1 on the next cycle; hold sel -> chg=0 on the following edge.
REQ-029 y_q=1001, en=0, sel changed to 2 over several edges -> y=0011 immediately, y_q stays 1001, chg stays 0.
REQ-030 rst asserted between clock edges while y_q=0011 -> y_q=0000 and chg=0 immediately, while y still tracks sel.
REQ-031 en=1, sel=3, d changed 0001->1111 just before an edge -> y_q=1111 after that edge, chg=1.
REQ-032 Exhaustive sweep of sel against random a/b/c/d vectors -> y always matches the selected input, and y_q matches it one enabled edge later.

Source files
------------

// File: rtl/mux_4bits.sv
// rtl/mux_4bits.sv - 4:1 data mux with one-hot select decode and an enabled output register
// Combinational y/sel_oh ignore clk, rst and en; y_q/chg are the only registered state.
module mux_4bits #(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [3:0]       sel_oh,
  output logic             chg
);

  // Nested ternaries rather than a case so an X on sel propagates to y instead of being masked.
  always_comb begin
    y      = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
    sel_oh = 4'b0001 << sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= RST_VAL;
      chg <= 1'b0;
    end else begin
      chg <= en && (y != y_q);
      if (en) begin
        y_q <= y;
      end
    end
  end

endmodule

// File: tb/tb_mux_4bits.sv
// tb/tb_mux_4bits.sv - directed and randomised self-checking bench for mux_4bits
module tb_mux_4bits;

  logic       clk = 1'b0;
  logic       run = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a = 4'b0101;
  logic [3:0] b = 4'b1001;
  logic [3:0] c = 4'b0011;
  logic [3:0] d = 4'b0001;
  logic [1:0] sel = 2'd0;
  logic       en = 1'b0;
  logic [3:0] y;
  logic [3:0] y_q;
  logic [3:0] sel_oh;
  logic       chg;

  int checks = 0;
  int failures = 0;

  mux_4bits #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .sel(sel), .en(en), .y(y), .y_q(y_q), .sel_oh(sel_oh), .chg(chg)
  );

  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_y  [4] = '{4'b0101, 4'b1001, 4'b0011, 4'b0001};
  logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    logic [3:0] vec [4];
    logic [3:0] prev;
    logic [3:0] want;

    #1 rst = 1'b1;
    #1;
    check("reset_y_q", y_q, 4'b0000);
    check("reset_chg", chg, 1'b0);

    // no clock running: pure combinational select
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #2;
      check($sformatf("comb_y_sel%0d", i), y, exp_y[i]);
      check($sformatf("comb_oh_sel%0d", i), sel_oh, exp_oh[i]);
    end

    rst = 1'b0;
    en  = 1'b1;
    sel = 2'd1;
    run = 1'b1;
    tick();
    check("load_b_y_q", y_q, 4'b1001);
    check("load_b_chg", chg, 1'b1);
    tick();
    check("hold_sel_chg", chg, 1'b0);
    check("hold_sel_y_q", y_q, 4'b1001);

    en  = 1'b0;
    sel = 2'd2;
    #1;
    check("en0_y_now", y, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en0_y_q_hold", y_q, 4'b1001);
      check("en0_chg", chg, 1'b0);
    end

    en = 1'b1;
    tick();
    check("load_c_y_q", y_q, 4'b0011);
    check("load_c_chg", chg, 1'b1);

    // async reset between edges, held across an enabled edge
    #2 rst = 1'b1;
    #1;
    check("async_rst_y_q", y_q, 4'b0000);
    check("async_rst_chg", chg, 1'b0);
    sel = 2'd0;
    #1;
    check("rst_y_tracks", y, 4'b0101);
    check("rst_oh_tracks", sel_oh, 4'b0001);
    tick();
    check("rst_over_en_y_q", y_q, 4'b0000);
    check("rst_over_en_chg", chg, 1'b0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_y_q", y_q, 4'b0101);
    check("post_rst_chg", chg, 1'b1);

    sel = 2'd3;
    tick();
    check("load_d_y_q", y_q, 4'b0001);
    #8 d = 4'b1111;
    tick();
    check("late_d_y_q", y_q, 4'b1111);
    check("late_d_chg", chg, 1'b1);

    // random sweep; sel and data change together before each edge
    prev = y_q;
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < 4; s++) begin
        for (int k = 0; k < 4; k++) vec[k] = 4'($urandom_range(0, 15));
        a = vec[0]; b = vec[1]; c = vec[2]; d = vec[3];
        sel = 2'(s);
        want = vec[s];
        #1;
        check("sweep_y", y, want);
        tick();
        check("sweep_y_q", y_q, want);
        check("sweep_chg", chg, (want != prev) ? 1'b1 : 1'b0);
        prev = want;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
